// File: rtl/mmio_pkg.sv
// Shared constants for the UART TX I/O page: page address, register offsets, bit indices, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmio_pkg;
  localparam logic [19:0] ADDR_UART = 20'h10005;

  // Register offsets, taken from address bits [3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  // STATUS bit positions
  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_OVF = 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; pointers carry an extra wrap bit so full and empty differ.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes while full are ignored, pops while empty are ignored; flush overrides both.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  assign o_empty    = (wr_ptr_q == rd_ptr_q);
  assign o_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_count    = wr_ptr_q - rd_ptr_q;
  assign o_pop_data = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok    = i_push && !o_full && !i_flush;
  assign pop_ok     = i_pop && !o_empty && !i_flush;

  // Storage array; no reset needed since occupancy is tracked by the pointers
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= i_push_data;
  end

  // Pointer update; flush collapses the queue to empty in one cycle
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the LSU I/O page 0x10005 with a byte FIFO.
// Latency: loads return one cycle after the address; a TXDATA store drives the start bit two cycles later.
// Backpressure: none on the bus; stores to a full FIFO are dropped and flagged by sticky overflow.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  output logic [31:0] o_ld_data,
  output logic        o_sel_r,
  output logic        o_uart_tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic           sel, wr, wr_txdata, wr_div, wr_ctrl;
  logic           flush, clr_ovf, push, pop;
  logic [1:0]     off;
  logic [7:0]     fifo_dout;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [15:0]    div_q;
  logic           en_q, ovf_q;
  uart_tx_state_t state_q;
  logic [15:0]    cnt_q;
  logic [2:0]     idx_q;
  logic [7:0]     shreg_q;
  logic           tx_q;
  logic [31:0]    status;
  logic [31:0]    rd_data_d;
  logic [31:0]    ld_data_q;
  logic           sel_q;
  logic           unused_bits;

  assign sel       = (i_lsu_addr[31:12] == ADDR_UART);
  assign off       = i_lsu_addr[3:2];
  assign wr        = sel && i_lsu_wren;
  assign wr_txdata = wr && (off == REG_TXDATA);
  assign wr_div    = wr && (off == REG_DIVISOR);
  assign wr_ctrl   = wr && (off == REG_CTRL);
  assign flush     = wr_ctrl && i_st_data[CTRL_FLUSH];
  assign clr_ovf   = wr_ctrl && i_st_data[CTRL_CLR_OVF];
  assign push      = wr_txdata && !flush;
  assign pop       = (state_q == IDLE) && en_q && !fifo_empty;
  assign unused_bits = ^{i_lsu_addr[11:4], i_lsu_addr[1:0], i_st_data[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (push),
    .i_push_data(i_st_data[7:0]),
    .i_pop      (pop),
    .i_flush    (flush),
    .o_pop_data (fifo_dout),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty),
    .o_count    (fifo_count)
  );

  // Configuration registers and sticky overflow; a zero divisor would stall the baud counter, so it is stored as 1
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      div_q <= DIV_RESET;
      en_q  <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      if (wr_div)  div_q <= (i_st_data[15:0] == 16'd0) ? 16'd1 : i_st_data[15:0];
      if (wr_ctrl) en_q  <= i_st_data[CTRL_EN];
      if (clr_ovf)                ovf_q <= 1'b0;
      else if (push && fifo_full) ovf_q <= 1'b1;
    end
  end

  // TX FSM with baud down-counter; the line level is registered and changes on bit boundaries only
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shreg_q <= fifo_dout;
            cnt_q   <= div_q - 16'd1;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == 16'd0) begin
            cnt_q   <= div_q - 16'd1;
            idx_q   <= 3'd0;
            tx_q    <= shreg_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == 16'd0) begin
            cnt_q <= div_q - 16'd1;
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              idx_q   <= idx_q + 3'd1;
              shreg_q <= shreg_q >> 1;
              tx_q    <= shreg_q[1];
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (cnt_q == 16'd0) state_q <= IDLE;
          else                cnt_q   <= cnt_q - 16'd1;
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Read mux; unselected cycles produce zero so the LSU can OR/select pages freely
  always_comb begin
    status                      = '0;
    status[ST_BUSY]             = (state_q != IDLE);
    status[ST_FULL]             = fifo_full;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_OVF]              = ovf_q;
    status[ST_COUNT_LSB +: 4]   = 4'(fifo_count);
    rd_data_d = '0;
    if (sel) begin
      case (off)
        REG_STATUS:  rd_data_d = status;
        REG_DIVISOR: rd_data_d = {16'd0, div_q};
        REG_CTRL:    rd_data_d = {31'd0, en_q};
        default:     rd_data_d = '0;
      endcase
    end
  end

  // Registered read response, matching data-memory load latency
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sel_q     <= 1'b0;
      ld_data_q <= '0;
    end else begin
      sel_q     <= sel;
      ld_data_q <= rd_data_d;
    end
  end

  assign o_ld_data = ld_data_q;
  assign o_sel_r   = sel_q;
  assign o_uart_tx = tx_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame shape, FIFO limits, flush and reset.
// Latency: inputs change 1ns after each rising edge; outputs are sampled at the same point.
// Backpressure: n/a.
module tb_mmio_uart_tx;
  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic        i_lsu_wren;
  logic [31:0] o_ld_data;
  logic        o_sel_r;
  logic        o_uart_tx;

  int          vecs;
  int          miss;
  logic [31:0] rd;
  logic        rs;
  logic [7:0]  ovf_bytes [9];

  mmio_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_lsu_addr(i_lsu_addr),
    .i_st_data (i_st_data),
    .i_lsu_wren(i_lsu_wren),
    .o_ld_data (o_ld_data),
    .o_sel_r   (o_sel_r),
    .o_uart_tx (o_uart_tx)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] ua(input logic [1:0] off);
    return {20'h10005, 8'h00, off, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wr_addr(input logic [31:0] a, input logic [31:0] d);
    i_lsu_addr = a;
    i_st_data  = d;
    i_lsu_wren = 1'b1;
    tick(1);
    i_lsu_wren = 1'b0;
    i_lsu_addr = '0;
    i_st_data  = '0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    wr_addr(ua(off), d);
  endtask

  task automatic rd_addr(input logic [31:0] a, output logic [31:0] d, output logic s);
    i_lsu_addr = a;
    i_lsu_wren = 1'b0;
    tick(1);
    d = o_ld_data;
    s = o_sel_r;
    i_lsu_addr = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] d;
    logic        s;
    rd_addr(ua(off), d, s);
    chk(tag, d, exp);
  endtask

  // Checks the line every cycle of one frame, starting at frame cycle 'skip'
  task automatic expect_frame(input string tag, input logic [7:0] b, input int div, input int skip);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int c = skip; c < 10 * div; c++) begin
      chk($sformatf("%s_c%0d", tag, c), {31'd0, o_uart_tx}, {31'd0, f[c / div]});
      tick(1);
    end
  endtask

  task automatic line_chk(input string tag, input logic exp);
    chk(tag, {31'd0, o_uart_tx}, {31'd0, exp});
  endtask

  initial begin
    vecs = 0;
    miss = 0;
    i_reset    = 1'b0;
    i_lsu_addr = '0;
    i_st_data  = '0;
    i_lsu_wren = 1'b0;
    ovf_bytes[0] = 8'h01; ovf_bytes[1] = 8'h80; ovf_bytes[2] = 8'hFF;
    ovf_bytes[3] = 8'h00; ovf_bytes[4] = 8'hA5; ovf_bytes[5] = 8'h5A;
    ovf_bytes[6] = 8'hC3; ovf_bytes[7] = 8'h3C; ovf_bytes[8] = 8'hEE;

    // Reset state
    tick(3);
    line_chk("rst_line", 1'b1);
    chk("rst_ld_data", o_ld_data, 32'h0);
    chk("rst_sel", {31'd0, o_sel_r}, 32'h0);
    i_reset = 1'b1;
    tick(1);
    rd_chk("rst_status", REG_STATUS_OFF(), 32'h0000_0004);
    rd_chk("rst_divisor", 2'd2, 32'd434);
    rd_chk("rst_ctrl", 2'd3, 32'h1);
    rd_addr(ua(2'd0), rd, rs);
    chk("txdata_reads0", rd, 32'h0);
    chk("txdata_sel", {31'd0, rs}, 32'h1);
    rd_addr({20'h10004, 12'h008}, rd, rs);
    chk("other_page_data", rd, 32'h0);
    chk("other_page_sel", {31'd0, rs}, 32'h0);
    wr_addr({20'h10004, 12'h008}, 32'd7);
    rd_chk("other_page_no_write", 2'd2, 32'd434);

    // Single frame, DIVISOR=4, byte 0x55
    wr(2'd2, 32'd4);
    rd_chk("div4", 2'd2, 32'd4);
    wr(2'd0, 32'h55);
    line_chk("f55_n1_high", 1'b1);
    tick(1);
    expect_frame("f55", 8'h55, 4, 0);
    rd_chk("f55_idle_status", 2'd1, 32'h0000_0004);

    // Overflow with TX disabled, then drain 8 back-to-back frames
    wr(2'd3, 32'h0);
    for (int k = 0; k < 9; k++) wr(2'd0, {24'd0, ovf_bytes[k]});
    rd_chk("ovf_status", 2'd1, 32'h0000_080A);
    wr(2'd3, 32'h4);
    rd_chk("ovf_cleared", 2'd1, 32'h0000_0802);
    wr(2'd3, 32'h1);
    line_chk("drain_n1_high", 1'b1);
    tick(1);
    for (int k = 0; k < 8; k++) begin
      expect_frame($sformatf("drain%0d", k), ovf_bytes[k], 4, 0);
      if (k < 7) begin
        line_chk($sformatf("gap%0d", k), 1'b1);
        tick(1);
      end
    end
    rd_chk("drain_done", 2'd1, 32'h0000_0004);

    // Store on the exact cycle IDLE pops: count stays at 1
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h96);
    rd_chk("one_queued", 2'd1, 32'h0000_0100);
    wr(2'd3, 32'h1);
    wr(2'd0, 32'h69);
    line_chk("pp_start", 1'b0);
    rd_chk("pp_count", 2'd1, 32'h0000_0101);
    expect_frame("ppA", 8'h96, 4, 1);
    line_chk("pp_gap", 1'b1);
    tick(1);
    expect_frame("ppB", 8'h69, 4, 0);
    rd_chk("pp_done", 2'd1, 32'h0000_0004);

    // Flush mid-frame with three bytes still queued
    wr(2'd3, 32'h0);
    wr(2'd0, 32'hE1);
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    wr(2'd0, 32'h33);
    wr(2'd3, 32'h1);
    line_chk("fl_n1_high", 1'b1);
    tick(1);
    line_chk("fl_start", 1'b0);
    tick(5);
    wr(2'd3, 32'h3);
    expect_frame("fl", 8'hE1, 4, 6);
    for (int c = 0; c < 50; c++) begin
      line_chk($sformatf("fl_quiet%0d", c), 1'b1);
      tick(1);
    end
    rd_chk("fl_status", 2'd1, 32'h0000_0004);
    rd_chk("fl_ctrl", 2'd3, 32'h1);

    // DIVISOR=0 is stored as 1: 10-cycle frames
    wr(2'd2, 32'h0);
    rd_chk("div0_reads1", 2'd2, 32'd1);
    wr(2'd0, 32'hA3);
    line_chk("d1_n1_high", 1'b1);
    tick(1);
    expect_frame("d1", 8'hA3, 1, 0);
    line_chk("d1_after", 1'b1);
    rd_chk("d1_status", 2'd1, 32'h0000_0004);

    // Reset asserted in the middle of a DATA bit
    wr(2'd2, 32'd4);
    wr(2'd3, 32'h0);
    wr(2'd0, 32'hF0);
    wr(2'd0, 32'h77);
    wr(2'd3, 32'h1);
    tick(1);
    line_chk("mr_start", 1'b0);
    tick(5);
    line_chk("mr_data0", 1'b0);
    i_reset = 1'b0;
    #2;
    line_chk("mr_async_high", 1'b1);
    chk("mr_sel", {31'd0, o_sel_r}, 32'h0);
    tick(2);
    i_reset = 1'b1;
    tick(1);
    rd_chk("mr_status", 2'd1, 32'h0000_0004);
    rd_chk("mr_divisor", 2'd2, 32'd434);
    rd_chk("mr_ctrl", 2'd3, 32'h1);
    for (int c = 0; c < 20; c++) begin
      line_chk($sformatf("mr_quiet%0d", c), 1'b1);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  function automatic logic [1:0] REG_STATUS_OFF();
    return 2'd1;
  endfunction
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that acts as the responder for the load/store unit's I/O window at page `20'h10005`, beside the LED, HEX, LCD and switch pages. It accepts word stores carrying TX bytes, control and baud settings. Bytes are queued in a small FIFO and serialized 8N1, LSB first, on `o_uart_tx`. Loads return status and configuration with the same one-cycle registered read latency as data memory, so the LSU read mux can select it alongside RAM and the other I/O pages.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `DIV_RESET`, 16'd434: reset value of DIVISOR, in clock cycles per bit (50 MHz / 115200).
- `i_clk`  in  1  clock; all state on rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_lsu_addr`  in  32  LSU address; block selected when `[31:12] == 20'h10005`; register offset is `[3:2]`.
- `i_st_data`  in  32  store data.
- `i_lsu_wren`  in  1  store strobe; a write takes effect only when this is high and the block is selected.
- `o_ld_data`  out  32  read data; valid the cycle after the address is presented.
- `o_sel_r`  out  1  registered select; high when the previous cycle's address hit this page.
- `o_uart_tx`  out  1  serial line; idles high.

## Operation
Register map (offset `[3:2]`):
- **0 TXDATA**
  - Write: pushes `i_st_data[7:0]`.
  - Read: returns 0.
- **1 STATUS**, read-only:
  - bit0 `busy`: FSM is not IDLE.
  - bit1 `full`.
  - bit2 `empty`.
  - bit3 `overflow`: sticky.
  - bits[11:8] `count`: FIFO occupancy.
  - Other bits read 0.
- **2 DIVISOR**
  - Read/write `[15:0]`; upper bits read 0.
  - A written value of 0 is stored as 1.
- **3 CTRL**
  - bit0 `enable`: read/write; reset value 1.
  - bit1 `flush`: write-1 pulse; reads 0.
  - bit2 `clr_ovf`: write-1 pulse; reads 0.

Push and FIFO behaviour:
- A push to a full FIFO is dropped and sets `overflow`.
- A push and a pop in the same cycle are both performed; `count` is unchanged.
- `flush` empties the FIFO at once. A frame already in flight still completes.
- If `flush` and a push happen in the same cycle, flush wins: the byte is dropped and `overflow` is unaffected.

TX state machine: `IDLE → START → DATA → STOP → IDLE`.
- **IDLE**
  - Line is high.
  - When `enable` is set and the FIFO is not empty: pop into the 8-bit shift register, load the baud counter, go to START.
- **START**: line is low for one bit period.
- **DATA**
  - Eight bit periods, LSB first, shifting right.
  - A 3-bit index counts 0..7; at the end of index 7, go to STOP.
- **STOP**
  - Line is high for one bit period, then IDLE.
  - When the FIFO is not empty and `enable` is set, IDLE pops on the very next cycle. Back-to-back frames are therefore separated by exactly one idle-high cycle.

Baud and mid-frame rules:
- One bit period is DIVISOR cycles. The down-counter reloads with DIVISOR−1 at each bit boundary.
- A DIVISOR write mid-frame takes effect at the next bit boundary.
- Clearing `enable` mid-frame lets the current frame finish; no new pop occurs.

Read path:
- Select, offset and the read value are registered on the address cycle.
- `o_ld_data` is 0 whenever `o_sel_r` is 0.

Reset values:
- `o_uart_tx` = 1.
- `o_ld_data` = 0, `o_sel_r` = 0.
- FIFO empty, FSM in IDLE, `overflow` = 0.
- DIVISOR = `DIV_RESET`, `enable` = 1.
- Reset asserted mid-frame drives the line high immediately and discards the FIFO contents.

## Timing
- Store to TXDATA in cycle N (idle, empty, enabled):
  - FIFO is non-empty at N+1 and the pop occurs at N+1.
  - `o_uart_tx` (registered) goes low from N+2.
- Frame length is 10×DIVISOR cycles; `busy` is high from N+2 through the last STOP cycle.
- Load issued in cycle N returns `o_ld_data`/`o_sel_r` in N+1. STATUS shows state as of the end of cycle N.
- A store and a load to the same register in one cycle are impossible (LSU issues one op per cycle).
- Control writes take effect in cycle N+1.

## Structure
- `mmio_pkg` holds:
  - `ADDR_UART = 20'h10005`.
  - Register offset constants.
  - STATUS/CTRL bit indices.
  - `uart_tx_state_t` enum (IDLE, START, DATA, STOP).
- Sub-module `sync_fifo` (parameters: width 8, depth).
  - Ports: push, pop, flush, full, empty, count.
  - Pointers are one bit wider than the address to distinguish full from empty.
  - Reset is async active-low.
- Top level holds decode, registers, the read mux, the baud counter and the FSM.

## Test plan
- Reset, no stimulus → `o_uart_tx`=1, `o_ld_data`=0, STATUS reads `0x0000_0004`, DIVISOR reads 434, CTRL reads 1.
- DIVISOR←4, TXDATA←`0x55` → line low from 2 cycles after the store. Then 4-cycle bits: start 0, data 1,0,1,0,1,0,1,0, stop 1, for 40 cycles total. STATUS `busy` drops after the stop bit.
- With CTRL `enable`=0, store 9 bytes → STATUS `count`=8, `full`=1, `overflow`=1. CTRL←`0x4` clears `overflow`. Re-enabling sends 8 frames, each separated by one idle cycle.
- Store timed on the cycle IDLE pops a queued byte → `count` is unchanged that cycle. Both bytes are transmitted in order.
- Mid-frame with 3 bytes queued, CTRL←`0x3` (flush) → current frame completes, then the line stays high and STATUS reads empty.
- DIVISOR←0 → reads back 1, and frames are 10 cycles long.
- Reset asserted mid-DATA → `o_uart_tx`=1 asynchronously. After release, STATUS reads `0x0000_0004`.
